// File: rtl/quad2pos.sv
// quad2pos: quadrature decoder with input synchronizer, per-bit glitch filter,
// Gray-step decode and a clamped or wrapping position register.
module quad2pos #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int POS_WIDTH   = 8,
  parameter int POS_MIN     = 0,
  parameter int POS_MAX     = 255,
  parameter int POS_RESET   = 128,
  parameter bit CLAMP       = 1
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic [1:0]           quad,
  input  logic                 clear,
  output logic [POS_WIDTH-1:0] pos,
  output logic                 step_left,
  output logic                 step_right,
  output logic                 dir,
  output logic                 err
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam int PW = POS_WIDTH + 1;
  localparam logic [PW-1:0] PMIN = PW'(POS_MIN);
  localparam logic [PW-1:0] PMAX = PW'(POS_MAX);
  localparam logic [CW-1:0] FLAST = CW'(FILTER_LEN - 1);
  localparam logic [POS_WIDTH-1:0] PRST = POS_WIDTH'(POS_RESET);

  typedef enum logic {INIT, RUN} state_t;

  state_t                 state_q;
  logic [1:0]             sync_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] fill_q;
  logic [1:0]             filt_q, prev_q, s, ip, ic, delta;
  logic [CW-1:0]          cnt_q [2];
  logic [POS_WIDTH-1:0]   pos_q, pos_d;
  logic [PW-1:0]          pw, up, dn;
  logic                   run, right, left, bad, settled, hi, lo;
  logic                   sl_q, sr_q, dir_q, err_q;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge CLK or posedge reset)
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      fill_q <= '0;
    end else begin
      sync_q[0] <= quad;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
    end

  always_ff @(posedge CLK or posedge reset)
    if (reset) begin
      filt_q   <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++)
        if (s[i] == filt_q[i]) cnt_q[i] <= '0;
        else if (cnt_q[i] == FLAST) begin
          filt_q[i] <= s[i];
          cnt_q[i]  <= '0;
        end else cnt_q[i] <= cnt_q[i] + 1'b1;
    end

  // Gray pair mapped to a 0..3 phase; phase delta 1 = right, 3 = left, 2 = illegal
  always_comb begin
    run     = state_q == RUN;
    ip      = {prev_q[0], prev_q[1] ^ prev_q[0]};
    ic      = {filt_q[0], filt_q[1] ^ filt_q[0]};
    delta   = ic - ip;
    right   = run && delta == 2'd1;
    left    = run && delta == 2'd3;
    bad     = run && delta == 2'd2;
    settled = fill_q[SYNC_STAGES-1] && cnt_q[0] == '0 && cnt_q[1] == '0 && s == filt_q;
    pw      = {1'b0, pos_q};
    up      = pw + 1'b1;
    dn      = pw - 1'b1;
    hi      = up > PMAX;
    lo      = dn[PW-1] || dn < PMIN;
    pos_d   = clear ? PRST
            : right ? (hi ? (CLAMP ? pos_q : PMIN[POS_WIDTH-1:0]) : up[POS_WIDTH-1:0])
            : left  ? (lo ? (CLAMP ? pos_q : PMAX[POS_WIDTH-1:0]) : dn[POS_WIDTH-1:0])
            : pos_q;
  end

  // INIT leaves only once the sync chain is filled and both filters agree with it
  always_ff @(posedge CLK or posedge reset)
    if (reset) begin
      state_q <= INIT;
      prev_q  <= '0;
      pos_q   <= PRST;
      sl_q    <= 1'b0;
      sr_q    <= 1'b0;
      err_q   <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      pos_q <= pos_d;
      sr_q  <= right;
      sl_q  <= left;
      err_q <= bad;
      if (right || left) dir_q <= right;
      if (run || settled) begin
        prev_q  <= filt_q;
        state_q <= RUN;
      end
    end

  assign pos        = pos_q;
  assign step_left  = sl_q;
  assign step_right = sr_q;
  assign dir        = dir_q;
  assign err        = err_q;
endmodule
